// File: rtl/cog_hub_port.sv
// cog_hub_port: cog-side initiator for the shared hub bus.
//
// Takes one hub operation at a time from the cog core. It waits for this cog's
// slot, drives the bus for exactly that one slot, and waits for the hub
// acknowledge. It then captures the returned data and carry and pulses done.
// If the acknowledge never arrives, err pulses after ACK_TIMEOUT strobes.
//
// Ports:
//   clk_cog, nres          clock, asynchronous active-low reset
//   ena_bus                hub slot strobe; every bus handshake qualifies on it
//   cog_ena                cog enabled; low aborts any operation
//   bus_sel, bus_ack       this cog's slot is current / hub acknowledge
//   bus_q, bus_c           hub read data (or sys result) and carry
//   req, req_r/w/s/a/d     core request: valid, read, write, size, address, data
//   bus_r/e/w/s/a/d        driven bus fields; all zero outside the issue cycle
//   busy, done, err        in progress / completion pulse / timeout pulse
//   rsp_q, rsp_c           captured bus_q / bus_c
module cog_hub_port #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TW          = 5
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena_bus,
    input  logic        cog_ena,
    input  logic        bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_q,
    input  logic        bus_c,
    input  logic        req,
    input  logic        req_r,
    input  logic        req_w,
    input  logic [1:0]  req_s,
    input  logic [15:0] req_a,
    input  logic [31:0] req_d,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rsp_q,
    output logic        rsp_c
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitSlot = 2'd1,
        StIssued   = 2'd2,
        StCapture  = 2'd3
    } state_e;

    localparam logic [TW-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TIMEOUT);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          lat_r_q, lat_w_q;
    logic [1:0]    lat_s_q;
    logic [15:0]   lat_a_q;
    logic [31:0]   lat_d_q;
    logic          latch_en;
    logic          issue;
    logic          capture;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        latch_en = 1'b0;
        issue    = 1'b0;
        capture  = 1'b0;
        // A disabled cog abandons whatever it was doing, silently.
        if (!cog_ena) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        latch_en = 1'b1;
                        state_d  = StWaitSlot;
                    end
                end
                StWaitSlot: begin
                    if (ena_bus && bus_sel) begin
                        issue   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIssued;
                    end
                end
                StIssued: begin
                    if (ena_bus) begin
                        // Ack beats a timeout that lands on the same strobe.
                        if (bus_ack) begin
                            state_d = StCapture;
                        end else begin
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                            if ((ACK_TIMEOUT != 0) && (cnt_d == ACK_LIM)) begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StCapture: begin
                    capture = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Bus fields are non-zero only during the issue cycle so that the hub can
    // OR together the outputs of all cogs.
    always_comb begin
        bus_e = 1'b0;
        bus_r = 1'b0;
        bus_w = 1'b0;
        bus_s = 2'b00;
        bus_a = 16'h0000;
        bus_d = 32'h0000_0000;
        if (issue) begin
            bus_e = 1'b1;
            bus_r = lat_r_q;
            bus_w = lat_w_q;
            bus_s = lat_s_q;
            bus_d = lat_d_q;
            bus_a = lat_a_q;
            if (lat_s_q == 2'b01) begin
                bus_a[0] = 1'b0;
            end else if (lat_s_q == 2'b10) begin
                bus_a[1:0] = 2'b00;
            end
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lat_r_q <= 1'b0;
            lat_w_q <= 1'b0;
            lat_s_q <= 2'b00;
            lat_a_q <= 16'h0000;
            lat_d_q <= 32'h0000_0000;
            rsp_q   <= 32'h0000_0000;
            rsp_c   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch_en) begin
                lat_r_q <= req_r;
                lat_w_q <= req_w;
                lat_s_q <= req_s;
                lat_a_q <= req_a;
                lat_d_q <= req_d;
            end
            if (capture) begin
                rsp_q <= bus_q;
                rsp_c <= bus_c;
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_cog_hub_port.sv
module tb_cog_hub_port;

    localparam int unsigned ACK_TIMEOUT = 4;
    localparam int unsigned TW          = 3;
    localparam int EV_ISSUE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;
    localparam int OUT_ABORT = -1;

    typedef struct {
        int          kind;
        int unsigned cyc;
        logic        r;
        logic        w;
        logic [1:0]  s;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] q;
        logic        c;
    } ev_t;

    logic        clk_cog = 1'b0;
    logic        nres    = 1'b0;
    logic        ena_bus = 1'b0;
    logic        cog_ena = 1'b1;
    logic        bus_sel = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_q   = 32'h0;
    logic        bus_c   = 1'b0;
    logic        req     = 1'b0;
    logic        req_r   = 1'b0;
    logic        req_w   = 1'b0;
    logic [1:0]  req_s   = 2'b00;
    logic [15:0] req_a   = 16'h0;
    logic [31:0] req_d   = 32'h0;
    logic        bus_r, bus_e, bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic        busy, done, err;
    logic [31:0] rsp_q;
    logic        rsp_c;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    ev_t         exp_q[$];
    ev_t         mon_e;
    // Reference state: last captured response.
    logic [31:0] m_q = 32'h0;
    logic        m_c = 1'b0;

    cog_hub_port #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .TW         (TW)
    ) dut (
        .clk_cog(clk_cog),
        .nres   (nres),
        .ena_bus(ena_bus),
        .cog_ena(cog_ena),
        .bus_sel(bus_sel),
        .bus_ack(bus_ack),
        .bus_q  (bus_q),
        .bus_c  (bus_c),
        .req    (req),
        .req_r  (req_r),
        .req_w  (req_w),
        .req_s  (req_s),
        .req_a  (req_a),
        .req_d  (req_d),
        .bus_r  (bus_r),
        .bus_e  (bus_e),
        .bus_w  (bus_w),
        .bus_s  (bus_s),
        .bus_a  (bus_a),
        .bus_d  (bus_d),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rsp_q  (rsp_q),
        .rsp_c  (rsp_c)
    );

    always #5 clk_cog = ~clk_cog;
    always @(posedge clk_cog) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_cog);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk_cog) begin
        if (nres) begin
            if (bus_e) begin
                if (exp_q.size() == 0 || exp_q[0].kind != EV_ISSUE) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got bus_e=1 at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("issue_r", 64'(bus_r), 64'(mon_e.r));
                    chk("issue_w", 64'(bus_w), 64'(mon_e.w));
                    chk("issue_s", 64'(bus_s), 64'(mon_e.s));
                    chk("issue_a", 64'(bus_a), 64'(mon_e.a));
                    chk("issue_d", 64'(bus_d), 64'(mon_e.d));
                end
            end else begin
                chk("bus_zero_when_idle", {bus_r, bus_w, bus_s, bus_a, bus_d}, 64'h0);
            end
            if (done) begin
                if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("done_rsp_q", 64'(rsp_q), 64'(mon_e.q));
                    chk("done_rsp_c", 64'(rsp_c), 64'(mon_e.c));
                    chk("done_busy", 64'(busy), 64'(0));
                end
            end
            if (err) begin
                if (exp_q.size() == 0 || exp_q[0].kind != EV_ERR) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_err: got err=1 at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("err_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("err_rsp_q_kept", 64'(rsp_q), 64'(mon_e.q));
                    chk("err_rsp_c_kept", 64'(rsp_c), 64'(mon_e.c));
                    chk("err_busy", 64'(busy), 64'(0));
                end
            end
        end
    end

    function automatic logic [15:0] align(input logic [1:0] s, input logic [15:0] a);
        if (s == 2'b10) return (a / 16'd4) * 16'd4;
        if (s == 2'b01) return (a / 16'd2) * 16'd2;
        return a;
    endfunction

    task automatic push(input int kind, input int unsigned c_at, input logic r, input logic w,
                        input logic [1:0] s, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] q, input logic c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c_at;
        e.r    = r;
        e.w    = w;
        e.s    = s;
        e.a    = a;
        e.d    = d;
        e.q    = q;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    // One operation. slot_n: strobe on which bus_sel is given; ack_n: strobe after issue
    // carrying bus_ack (0 = never); abort_n: strobe after issue with cog_ena low (0 = none).
    task automatic run_op(input logic r, input logic w, input logic [1:0] s, input logic [15:0] a,
                          input logic [31:0] d, input int slot_n, input int ack_n,
                          input int abort_n, input logic [31:0] q, input logic c);
        int   eff_ack, lim, outcome, nmax, ab, bound;
        logic acked;
        eff_ack = (ack_n >= 1 && ack_n <= int'(ACK_TIMEOUT)) ? ack_n : 0;
        lim     = (eff_ack != 0) ? eff_ack : int'(ACK_TIMEOUT);
        ab      = (abort_n > 0 && abort_n <= lim) ? abort_n : 0;
        if (ab != 0) outcome = OUT_ABORT;
        else if (eff_ack != 0) outcome = EV_DONE;
        else outcome = EV_ERR;

        req   = 1'b1;
        req_r = r;
        req_w = w;
        req_s = s;
        req_a = a;
        req_d = d;
        step();
        chk("busy_after_req", 64'(busy), 64'(1));
        // Request fields change freely once latched.
        req_r = 1'($urandom);
        req_w = 1'($urandom);
        req_s = 2'($urandom);
        req_a = 16'($urandom);
        req_d = $urandom;

        for (int k = 1; k <= slot_n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                ena_bus = 1'b0;
                bus_sel = 1'($urandom);
                bus_ack = 1'($urandom);
                bus_q   = $urandom;
                bus_c   = 1'($urandom);
                req     = 1'($urandom);
                step();
            end
            ena_bus = 1'b1;
            bus_sel = (k == slot_n);
            bus_ack = 1'b0;
            bus_q   = $urandom;
            req     = (k == slot_n) ? 1'b0 : 1'($urandom);
            if (k == slot_n) push(EV_ISSUE, cyc, r, w, s, align(s, a), d, 32'h0, 1'b0);
            step();
        end
        req = 1'b0;

        nmax = int'(ACK_TIMEOUT);
        if (ack_n > nmax) nmax = ack_n;
        nmax  = nmax + 1;
        acked = 1'b0;
        for (int n = 1; n <= nmax; n++) begin
            repeat ($urandom_range(0, 2)) begin
                ena_bus = 1'b0;
                bus_sel = 1'($urandom);
                bus_ack = 1'($urandom);
                if (!acked) begin
                    bus_q = $urandom;
                    bus_c = 1'($urandom);
                end
                step();
            end
            ena_bus = 1'b1;
            bus_sel = 1'($urandom);
            bus_ack = (n == ack_n);
            cog_ena = (n != ab);
            if (!acked) begin
                bus_q = $urandom;
                bus_c = 1'($urandom);
            end
            if (n == ack_n) begin
                bus_q = q;
                bus_c = c;
                acked = 1'b1;
                if (outcome == EV_DONE) begin
                    m_q = q;
                    m_c = c;
                    push(EV_DONE, cyc + 2, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, m_q, m_c);
                end
            end
            if (n == int'(ACK_TIMEOUT) && outcome == EV_ERR)
                push(EV_ERR, cyc + 1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, m_q, m_c);
            step();
            cog_ena = 1'b1;
        end
        ena_bus = 1'b0;
        bus_sel = 1'b0;
        bus_ack = 1'b0;
        bound = 0;
        while (busy && bound < 20) begin
            step();
            bound++;
        end
        chk("busy_release", 64'(busy), 64'(0));
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rs;
        logic [31:0] rq;
        int          an, ab;
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done_err", 64'({done, err}), 64'(0));
        chk("reset_rsp", 64'({rsp_c, rsp_q}), 64'(0));
        chk("reset_bus", {bus_e, bus_r, bus_w, bus_s, bus_a, bus_d}, 64'h0);
        nres = 1'b1;
        step();

        // rdlong, slot on 3rd strobe, ack two strobes later
        run_op(1'b1, 1'b0, 2'b10, 16'h1236, 32'h1111_2222, 3, 2, 0, 32'hDEAD_BEEF, 1'b0);
        chk("rdlong_rsp_q", 64'(rsp_q), 64'(32'hDEAD_BEEF));
        // wrword, misaligned address
        run_op(1'b0, 1'b1, 2'b01, 16'h0003, 32'h0000_ABCD, 1, 1, 0, 32'h5555_0000, 1'b0);
        // sys lockset with carry returned
        rq = $urandom;
        run_op(1'b0, 1'b0, 2'b11, 16'h0006, 32'h0000_0005, 2, 3, 0, rq, 1'b1);
        chk("sys_rsp_c", 64'(rsp_c), 64'(1));
        // timeout: ack never arrives
        run_op(1'b1, 1'b0, 2'b00, 16'h00F1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
        // ack on the same strobe as the timeout wins
        run_op(1'b1, 1'b0, 2'b00, 16'h0045, 32'h0, 2, int'(ACK_TIMEOUT), 0, 32'hCAFE_0001, 1'b1);
        // ack one strobe too late: timeout then ignored late ack
        run_op(1'b1, 1'b0, 2'b10, 16'h0101, 32'h0, 1, int'(ACK_TIMEOUT) + 1, 0, 32'h0BAD_0BAD,
               1'b0);
        // abort in ISSUED, ack arrives afterwards
        run_op(1'b1, 1'b0, 2'b10, 16'h2000, 32'h0, 1, 2, 1, 32'h0BAD_F00D, 1'b1);
        // abort on the same strobe as ack
        run_op(1'b1, 1'b0, 2'b01, 16'h2001, 32'h0, 1, 2, 2, 32'h0BAD_F00E, 1'b0);

        // async reset in WAIT_SLOT
        req   = 1'b1;
        req_r = 1'b1;
        req_w = 1'b0;
        req_s = 2'b10;
        req_a = 16'h4444;
        step();
        req     = 1'b0;
        ena_bus = 1'b1;
        step();
        ena_bus = 1'b0;
        chk("pre_reset_busy", 64'(busy), 64'(1));
        nres = 1'b0;
        #1;
        m_q = 32'h0;
        m_c = 1'b0;
        chk("async_reset_busy", 64'(busy), 64'(0));
        chk("async_reset_rsp", 64'({rsp_c, rsp_q}), 64'(0));
        chk("async_reset_flags", 64'({done, err}), 64'(0));
        #1;
        nres = 1'b1;
        step();
        run_op(1'b1, 1'b0, 2'b10, 16'h4447, 32'h0, 1, 1, 0, 32'h7777_8888, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom);
            an = $urandom_range(0, 6);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
            run_op(1'($urandom), 1'($urandom), rs, 16'($urandom), $urandom,
                   $urandom_range(1, 4), an, ab, $urandom, 1'($urandom));
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
